// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: bundles the instruction-memory request/response channel and
// the downstream head-instruction/redirect channel of the fetch stage.
// master = fetch stage, slave = surrounding memory + execution unit.
interface ifu_prefetch_if #(
  parameter int MAX_DELAY_WIDTH = 4
);
  logic                       imem_req_valid;
  logic [31:0]                imem_req_addr;
  logic                       imem_req_ready;
  logic                       imem_rsp_valid;
  logic [31:0]                imem_rsp_data;
  logic                       ifu_o_valid;
  logic [31:0]                ifu_o_ir;
  logic [31:0]                ifu_o_pc;
  logic [MAX_DELAY_WIDTH-1:0] ifu_o_cycle;
  logic                       exu_i_ready;
  logic                       exu_i_redirect;
  logic [31:0]                exu_i_redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_cycle,
    input  exu_i_ready, exu_i_redirect, exu_i_redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_cycle,
    output exu_i_ready, exu_i_redirect, exu_i_redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch/prefetch stage. Issues in-order word fetches
// under a credit limit, buffers responses in a small FIFO and presents the head
// instruction with its PC and a pre-decoded execution cycle count.
// Optional feature macro: IFU_PERF_CNT_EN adds ifu_o_stall_cnt.
// MAX_DELAY_WIDTH must match the parameter of the connected interface.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          ALU_CYCLES      = 1,
  parameter int          MUL_CYCLES      = 3,
  parameter int          DIV_CYCLES      = 8,
  parameter int          MAX_DELAY_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifu_prefetch_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]   ifu_o_stall_cnt
`endif
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int MDW     = MAX_DELAY_WIDTH;
  localparam int CYC_MAX = (1 << MDW) - 1;
  // Zero-valued cycle parameters mean "one cycle"; oversized ones saturate.
  localparam int ALU_I = (ALU_CYCLES <= 0) ? 1 : (ALU_CYCLES > CYC_MAX) ? CYC_MAX : ALU_CYCLES;
  localparam int MUL_I = (MUL_CYCLES <= 0) ? 1 : (MUL_CYCLES > CYC_MAX) ? CYC_MAX : MUL_CYCLES;
  localparam int DIV_I = (DIV_CYCLES <= 0) ? 1 : (DIV_CYCLES > CYC_MAX) ? CYC_MAX : DIV_CYCLES;
  localparam logic [MDW-1:0] ALU_C = MDW'(ALU_I);
  localparam logic [MDW-1:0] MUL_C = MDW'(MUL_I);
  localparam logic [MDW-1:0] DIV_C = MDW'(DIV_I);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;        // PC of the next response that will be kept
  logic [31:0]   pc_q [FIFO_DEPTH];
  logic [31:0]   ir_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, squash, out_after;
  logic          credit, req_fire, rsp_drop, push, pop, empty, redirect;
  logic [31:0]   redirect_pc, head_ir;
  logic [MDW-1:0] head_cyc;

  assign redirect    = bus.exu_i_redirect;
  assign redirect_pc = bus.exu_i_redirect_pc & ~32'h3;
  assign empty       = (count == '0);
  assign credit      = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);

  assign bus.imem_req_valid = ~rst & ~redirect & credit;
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_drop  = bus.imem_rsp_valid & (squash != '0);
  assign push      = bus.imem_rsp_valid & (squash == '0) & ~redirect;
  assign pop       = ~empty & bus.exu_i_ready & ~redirect;
  // Requests still in flight once this cycle's handshakes settle.
  assign out_after = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);

  // Control state: fetch PC, credit tracking, squash count and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      squash      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= out_after;
      if (redirect) begin
        // Everything still in flight belongs to the old path and gets dropped.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        squash   <= out_after;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) squash <= squash - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= rsp_pc;
      ir_q[wr_ptr] <= bus.imem_rsp_data;
    end
  end

  assign head_ir = ir_q[rd_ptr];

  // Pre-decode the execution latency of the head instruction.
  always_comb begin
    head_cyc = ALU_C;
    if (head_ir[6:0] == 7'b0000011 || head_ir[6:0] == 7'b0100011)
      head_cyc = MDW'(1);
    else if (head_ir[6:0] == 7'b0110011 && head_ir[31:25] == 7'b0000001)
      head_cyc = head_ir[14] ? DIV_C : MUL_C;
  end

  assign bus.ifu_o_valid = ~empty;
  assign bus.ifu_o_ir    = empty ? 32'h0 : head_ir;
  assign bus.ifu_o_pc    = empty ? 32'h0 : pc_q[rd_ptr];
  assign bus.ifu_o_cycle = empty ? '0 : head_cyc;

`ifdef IFU_PERF_CNT_EN
  // Count cycles where downstream is ready but no instruction is available.
  always_ff @(posedge clk) begin
    if (rst)
      ifu_o_stall_cnt <= 32'h0;
    else if (bus.exu_i_ready & empty & ~redirect & ~(&ifu_o_stall_cnt))
      ifu_o_stall_cnt <= ifu_o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: scoreboard bench for ifu_prefetch. The reference model says
// the delivered stream is exactly the accepted requests since the last
// redirect/reset, in order, with ir = memory image and cycles from opcode rules.
module tb_ifu_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MDW = 4;
  localparam int ALU = 1, MUL = 3, DIV = 8;

  typedef struct { logic [31:0] pc; logic [31:0] ir; logic [31:0] cyc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.MAX_DELAY_WIDTH(MDW)) bus ();
`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  ifu_prefetch #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(2), .ALU_CYCLES(ALU), .MUL_CYCLES(MUL),
    .DIV_CYCLES(DIV), .MAX_DELAY_WIDTH(MDW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef IFU_PERF_CNT_EN
    , .ifu_o_stall_cnt(stall_cnt)
`endif
  );

  int n_cmp = 0, n_fail = 0;
  int rsp_pct = 100;
  exp_t exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] model_pc = RESET_PC;

  // Memory image: a few fixed instructions, otherwise a hashed mix of classes.
  function automatic logic [31:0] ifn(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h200: return 32'h02C5_0533;
      32'h204: return 32'h02C5_4533;
      32'h208: return 32'h0005_2503;
      32'h20C: return 32'h0000_0013;
      default: ;
    endcase
    h = (a * 32'h9E37_79B1) ^ (a >> 11);
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0, 3'd1: return {7'b0000001, h[26:17], h[31:29], h[9:5], 7'b0110011};
      3'd2:       return {7'b0000000, h[26:17], h[31:29], h[9:5], 7'b0110011};
      3'd3:       return {h[31:7], 7'b0000011};
      3'd4:       return {h[31:7], 7'b0100011};
      default:    return h;
    endcase
  endfunction

  function automatic int clampc(input int v);
    if (v < 1) return 1;
    if (v > (1 << MDW) - 1) return (1 << MDW) - 1;
    return v;
  endfunction

  function automatic int ref_cycles(input logic [31:0] ir);
    if (ir[6:0] == 7'b0000011 || ir[6:0] == 7'b0100011) return 1;
    if (ir[6:0] == 7'b0110011 && ir[31:25] == 7'b0000001)
      return clampc(ir[14] ? DIV : MUL);
    return clampc(ALU);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: returns accepted requests in order, with random gaps.
  always @(posedge clk) begin
    #2;
    if (!rst && mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = ifn(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
  end

  // Monitor/scoreboard: records accepted requests, checks each popped head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, model_pc);
        e.pc = model_pc;
        e.ir = ifn(model_pc);
        e.cyc = ref_cycles(e.ir);
        exp_q.push_back(e);
        mem_q.push_back(model_pc);
        model_pc += 32'd4;
      end
      if (bus.ifu_o_valid && bus.exu_i_ready && !bus.exu_i_redirect) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc %h expected no valid head", bus.ifu_o_pc);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", bus.ifu_o_pc, e.pc);
          chk("head_ir", bus.ifu_o_ir, e.ir);
          chk("head_cycle", 32'(bus.ifu_o_cycle), e.cyc);
        end
      end
      if (bus.exu_i_redirect) begin
        chk("redirect_no_req", 32'(bus.imem_req_valid), 32'd0);
        exp_q.delete();
        model_pc = {bus.exu_i_redirect_pc[31:2], 2'b00};
      end
    end
  end

  initial begin
    int got;
    logic [31:0] a0;
    int cyc_tab[4];
    cyc_tab = '{3, 8, 1, 1};
    bus.imem_req_ready    = 1'b0;
    bus.imem_rsp_valid    = 1'b0;
    bus.imem_rsp_data     = 32'h0;
    bus.exu_i_ready       = 1'b0;
    bus.exu_i_redirect    = 1'b0;
    bus.exu_i_redirect_pc = 32'h0;

    // Reset state.
    step(); step();
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_o_valid", 32'(bus.ifu_o_valid), 32'd0);
    chk("rst_o_ir", bus.ifu_o_ir, 32'h0);
    chk("rst_o_pc", bus.ifu_o_pc, 32'h0);
    chk("rst_o_cycle", 32'(bus.ifu_o_cycle), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Release: first request at edge 1, response captured at edge 2.
    step(); rst = 1'b0; bus.imem_req_ready = 1'b1;
    step();
    @(negedge clk);
    chk("first_valid_early", 32'(bus.ifu_o_valid), 32'd0);
    step();
    @(negedge clk);
    chk("first_valid", 32'(bus.ifu_o_valid), 32'd1);
    chk("first_pc", bus.ifu_o_pc, RESET_PC);
    repeat (4) step();
    @(negedge clk);
    chk("full_no_req", 32'(bus.imem_req_valid), 32'd0);
    chk("full_addr", bus.imem_req_addr, RESET_PC + 32'd8);
    chk("full_head_pc", bus.ifu_o_pc, RESET_PC);

    // Build two outstanding requests, then redirect over them.
    step(); rsp_pct = 0; bus.exu_i_redirect = 1'b1; bus.exu_i_redirect_pc = 32'h300;
    step(); bus.exu_i_redirect = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("two_out_no_req", 32'(bus.imem_req_valid), 32'd0);
    chk("two_out_empty", 32'(bus.ifu_o_valid), 32'd0);
    step(); bus.exu_i_redirect = 1'b1; bus.exu_i_redirect_pc = 32'h103; rsp_pct = 100;
    step(); bus.exu_i_redirect = 1'b0;
    @(negedge clk);
    chk("redir_flushed", 32'(bus.ifu_o_valid), 32'd0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ifu_o_valid) begin got = 1; break; end
    end
    chk("redir_head_seen", got, 1);
    chk("redir_head_pc", bus.ifu_o_pc, 32'h100);

    // Cycle decode on fixed instructions at 0x200..0x20C.
    step(); bus.exu_i_redirect = 1'b1; bus.exu_i_redirect_pc = 32'h200;
    step(); bus.exu_i_redirect = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("decode_pc", bus.ifu_o_pc, 32'h200 + 32'(4 * i));
      chk("decode_cycle", 32'(bus.ifu_o_cycle), 32'(cyc_tab[i]));
      step(); bus.exu_i_ready = 1'b1;
      step(); bus.exu_i_ready = 1'b0;
      repeat (3) step();
    end

    // Memory stall: address must hold while the buffer drains.
    step(); bus.imem_req_ready = 1'b0; bus.exu_i_ready = 1'b1;
    @(negedge clk);
    a0 = bus.imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("stall_addr", bus.imem_req_addr, a0);
    end
    chk("stall_drained", 32'(bus.ifu_o_valid), 32'd0);

    // Reset with a full buffer.
    step(); bus.imem_req_ready = 1'b1; bus.exu_i_ready = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("prerst_full", 32'(bus.ifu_o_valid), 32'd1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 32'(bus.ifu_o_valid), 32'd0);
    chk("postrst_addr", bus.imem_req_addr, RESET_PC);
`ifdef IFU_PERF_CNT_EN
    chk("postrst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Randomized traffic: all checking happens in the scoreboard.
    rsp_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      step();
      bus.imem_req_ready = ($urandom_range(9) < 7);
      bus.exu_i_ready    = ($urandom_range(9) < 6);
      bus.exu_i_redirect = ($urandom_range(99) < 3);
      bus.exu_i_redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31)))
                                                       : 32'($urandom);
      rst = ($urandom_range(999) < 4);
    end
    step(); rst = 1'b0; bus.exu_i_redirect = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
